ntt_core_param: RTL and testbench
=================================

Name: ntt_core_param

Overview:
- Parametrised in-place N-point negacyclic NTT engine with forward and inverse modes, for the lattice-crypto datapath.
- Loads N coefficients over a valid/ready stream and runs log2(N) butterfly stages from an internal coefficient RAM.
- Forward mode uses Cooley-Tukey butterflies; inverse mode uses Gentleman-Sande butterflies, then an n^-1 scaling pass.
- Streams the N results out with full output backpressure. Twiddles come from an external ROM.

Parameters:
- LOGN, 8, log2 of transform size N (N = 2**LOGN, legal 2..10)
- W, 23, coefficient and twiddle width in bits
- Q, 8380417, prime modulus, Q < 2**W
- NINV, 8347681, N^-1 mod Q, used in the inverse scaling pass

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- mode  in  1  0 = forward, 1 = inverse; sampled on the first accepted input beat
- input_valid  in  1  input coefficient valid
- input_ready  out  1  core can accept a coefficient
- input_data  in  W  coefficient in natural order; required < Q, not checked
- tf_addr  out  LOGN  twiddle ROM index, combinational from internal counters
- tf_data  in  W  twiddle zeta[tf_addr]; the ROM is combinational, same cycle
- busy  out  1  high from the first accepted beat until the last output handshake
- output_valid  out  1  output coefficient valid
- output_ready  in  1  downstream accepts the coefficient
- output_data  out  W  result coefficient in natural index order, range [0,Q)

Behaviour:
- Reset values: input_ready=1, output_valid=0, output_data=0, busy=0, tf_addr=0; state IDLE; all counters 0. RAM contents are not reset.
- States: IDLE, LOAD, CALC, SCALE, OUTPUT.
- IDLE and LOAD:
  - input_ready=1.
  - A beat is accepted when input_valid & input_ready. Beat k is written to mem[k].
  - The first beat latches mode and moves IDLE to LOAD.
  - Gaps in input_valid are allowed; the input counter does not advance on a gap.
  - Acceptance of beat N-1 moves the core to CALC, and input_ready drops in that cycle's successor.
- CALC: one butterfly per cycle, N/2*LOGN cycles in total.
  - Counters: len, start, j, and twiddle index k.
  - Forward:
    - len starts at N/2 and halves per stage.
    - k starts at 1 and increments per block; tf_addr = k.
    - Butterfly: t = zeta*mem[j+len] mod Q; mem[j] = mem[j]+t mod Q; mem[j+len] = mem[j]-t mod Q.
  - Inverse:
    - len starts at 1 and doubles per stage.
    - k starts at N and pre-decrements per block; tf_addr = k-1.
    - zeta' = (Q - tf_data) mod Q.
    - Butterfly: mem[j] = mem[j]+mem[j+len] mod Q; mem[j+len] = zeta'*(mem[j]-mem[j+len]) mod Q, using old values.
  - Block walk: j runs start..start+len-1, then start += 2*len. When start reaches N, the stage ends, len is updated, and start and j reset to 0.
  - Exit: forward mode goes to OUTPUT; inverse mode goes to SCALE.
- SCALE (inverse only): N cycles; mem[i] = mem[i]*NINV mod Q for i = 0..N-1.
- Arithmetic rules:
  - Add and subtract results are reduced by a single conditional correction.
  - The product is 2W bits and is fully reduced mod Q.
  - Every stored value stays in [0,Q).
- OUTPUT:
  - output_data is registered. output_valid first rises the cycle after CALC or SCALE ends.
  - On output_valid & output_ready the core presents mem[i+1] next cycle.
  - While output_ready=0, output_valid and output_data hold stable.
  - After the handshake of index N-1: output_valid=0, busy=0, return to IDLE.
- Latency, forward: last input beat at cycle t → first output_valid at t+N/2*LOGN+1 (N=256: t+1025).
- Latency, inverse: add N cycles (N=256: t+1281).
- Input beats are not accepted outside IDLE/LOAD.
- mode changes after the first beat are ignored.
- Reset mid-operation returns the core to IDLE within one cycle. The partial result is discarded and output_valid falls immediately.

Decomposition:
- Shared package ntt_pkg: state encoding, the helper functions mod_add, mod_sub and mod_mul (parametrised by W and Q), and the mode constants FWD and INV.
- Sub-module ntt_bu_ctgs: combinational butterfly with inputs X, Y, TF, mode and outputs A, B.
  - Its multiplier is reused for the SCALE pass by driving X=0 in INV-bypass and TF=NINV.

Test Plan:
- Impulse forward: x[0]=1, others 0, mode=0 → all 256 outputs = 1; first output_valid 1025 cycles after the last beat.
- Impulse inverse: all inputs 1, mode=1 → out[0]=1, out[1..255]=0; latency 1281 cycles.
- Round trip: random vector < 8380417, forward, then feed the outputs back with mode=1 → the original vector is reproduced bit-exact.
- Backpressure: hold output_ready=0 for 5 cycles at output index 10 → output_data stays out[10], valid stays 1, no index skipped or duplicated, 256 handshakes total.
- Boundary values: x[0]=8380416 (Q-1), rest 0, forward → all outputs 8380416. Input gaps: input_valid toggled every other cycle → identical result.
- Reset mid-CALC: assert rst 300 cycles into CALC → next cycle input_ready=1, busy=0, output_valid=0; a new impulse transform then completes correctly.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT engine: FSM state encoding, transform
// direction constants and modular arithmetic helpers. The helpers work on
// 64-bit operands so one set of functions serves any W up to 31 bits.
package ntt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CALC,
    ST_SCALE,
    ST_OUTPUT
  } state_t;

  localparam logic FWD = 1'b0;
  localparam logic INV = 1'b1;

  // (a + b) mod q for a, b already in [0, q); one conditional correction.
  function automatic logic [63:0] mod_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] q);
    logic [63:0] s;
    s = a + b;
    if (s >= q) s = s - q;
    return s;
  endfunction

  // (a - b) mod q for a, b already in [0, q); one conditional correction.
  function automatic logic [63:0] mod_sub(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] q);
    logic [63:0] d;
    if (a >= b) d = a - b;
    else        d = a + q - b;
    return d;
  endfunction

  // Full 2W-bit product reduced completely into [0, q).
  function automatic logic [63:0] mod_mul(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] q);
    logic [63:0] p;
    p = a * b;
    return p % q;
  endfunction

endpackage

// File: rtl/ntt_core_param_if.sv
// Stream, twiddle-ROM and status signals of the NTT engine. The core
// takes the slave side; the environment (source, sink, ROM) the master side.
interface ntt_core_param_if #(
  parameter int LOGN = 8,
  parameter int W    = 23
);
  logic            mode;
  logic            input_valid;
  logic            input_ready;
  logic [W-1:0]    input_data;
  logic [LOGN-1:0] tf_addr;
  logic [W-1:0]    tf_data;
  logic            busy;
  logic            output_valid;
  logic            output_ready;
  logic [W-1:0]    output_data;

  modport master (
    output mode, input_valid, input_data, tf_data, output_ready,
    input  input_ready, tf_addr, busy, output_valid, output_data
  );

  modport slave (
    input  mode, input_valid, input_data, tf_data, output_ready,
    output input_ready, tf_addr, busy, output_valid, output_data
  );
endinterface

// File: rtl/ntt_bu_ctgs.sv
// Combinational butterfly shared by both directions. Forward is a
// Cooley-Tukey butterfly, inverse a Gentleman-Sande butterfly with the
// twiddle negated. With x=0 in inverse mode the b output degenerates to
// tf*y, which lets the core reuse the multiplier for the n^-1 scaling pass.
module ntt_bu_ctgs
  import ntt_pkg::*;
#(
  parameter int          W = 23,
  parameter int unsigned Q = 8380417
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] tf,
  input  logic         mode,
  output logic [W-1:0] a,
  output logic [W-1:0] b
);
  localparam logic [63:0] Q64 = 64'(Q);

  logic [63:0] x64, y64, tf64, zeta_neg, diff, mul_a, mul_b, prod;

  // One multiplier: forward multiplies zeta*y, inverse multiplies -zeta*(x-y).
  always_comb begin
    x64      = 64'(x);
    y64      = 64'(y);
    tf64     = 64'(tf);
    zeta_neg = (tf64 == 64'd0) ? 64'd0 : Q64 - tf64;
    diff     = mod_sub(x64, y64, Q64);
    mul_a    = (mode == INV) ? zeta_neg : tf64;
    mul_b    = (mode == INV) ? diff : y64;
    prod     = mod_mul(mul_a, mul_b, Q64);
    if (mode == INV) begin
      a = W'(mod_add(x64, y64, Q64));
      b = W'(prod);
    end else begin
      a = W'(mod_add(x64, prod, Q64));
      b = W'(mod_sub(x64, prod, Q64));
    end
  end

endmodule

// File: rtl/ntt_core_param.sv
// In-place N-point negacyclic NTT engine. Coefficients stream in, log2(N)
// butterfly stages run from a register-file RAM (one butterfly per cycle),
// inverse transforms get an n^-1 scaling pass, and results stream out in
// natural order with full backpressure.
module ntt_core_param
  import ntt_pkg::*;
#(
  parameter int          LOGN = 8,
  parameter int          W    = 23,
  parameter int unsigned Q    = 8380417,
  parameter int unsigned NINV = 8347681
) (
  input logic             clk,
  input logic             rst,
  ntt_core_param_if.slave bus
);
  localparam int N  = 1 << LOGN;
  localparam int CW = LOGN + 1;
  localparam logic [LOGN-1:0] LAST_IDX = LOGN'(N - 1);
  localparam logic [LOGN-1:0] HALF     = LOGN'(N / 2);
  localparam logic [LOGN-1:0] ONE      = LOGN'(1);
  localparam logic [CW-1:0]   N_END    = CW'(N);

  state_t          state;
  logic            mode_r;
  logic [LOGN-1:0] cnt;
  logic [LOGN-1:0] len;
  logic [LOGN-1:0] start;
  logic [LOGN-1:0] j;
  // Twiddle ROM address: k in forward mode, k-1 in inverse mode.
  logic [LOGN-1:0] tfi;
  logic            input_ready_r;
  logic            output_valid_r;
  logic            busy_r;
  logic [W-1:0]    output_data_r;
  logic [W-1:0]    mem [N];

  logic            accept, out_fire, eff_mode;
  logic            blk_end, stage_end, last_stage;
  logic [LOGN-1:0] jl;
  logic [CW-1:0]   next_start;
  logic [W-1:0]    bu_x, bu_y, bu_tf, bu_a, bu_b;
  logic            bu_mode;

  assign bus.input_ready  = input_ready_r;
  assign bus.output_valid = output_valid_r;
  assign bus.output_data  = output_data_r;
  assign bus.busy         = busy_r;
  assign bus.tf_addr      = (state == ST_CALC) ? tfi : '0;

  // Handshakes and block/stage walk decode for the current butterfly.
  always_comb begin
    accept     = bus.input_valid && input_ready_r;
    out_fire   = output_valid_r && bus.output_ready;
    eff_mode   = (state == ST_IDLE) ? bus.mode : mode_r;
    jl         = j + len;
    blk_end    = (j == start + len - ONE);
    next_start = CW'(start) + (CW'(len) << 1);
    stage_end  = blk_end && (next_start == N_END);
    last_stage = (mode_r == FWD) ? (len == ONE) : (len == HALF);
  end

  // Butterfly operands: RAM pair in CALC, (0, mem[i], NINV) bypass in SCALE.
  always_comb begin
    bu_x    = mem[j];
    bu_y    = mem[jl];
    bu_tf   = bus.tf_data;
    bu_mode = mode_r;
    if (state == ST_SCALE) begin
      bu_x    = '0;
      bu_y    = mem[cnt];
      bu_tf   = W'(NINV);
      bu_mode = INV;
    end
  end

  ntt_bu_ctgs #(.W(W), .Q(Q)) u_bu (
    .x    (bu_x),
    .y    (bu_y),
    .tf   (bu_tf),
    .mode (bu_mode),
    .a    (bu_a),
    .b    (bu_b)
  );

  // Coefficient RAM: load beats, butterfly results and scaled values.
  always_ff @(posedge clk) begin
    case (state)
      ST_IDLE, ST_LOAD: begin
        if (accept) mem[cnt] <= bus.input_data;
      end
      ST_CALC: begin
        mem[j]  <= bu_a;
        mem[jl] <= bu_b;
      end
      ST_SCALE: begin
        mem[cnt] <= bu_b;
      end
      default: ;
    endcase
  end

  // Main FSM with counters and registered stream/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      mode_r         <= FWD;
      cnt            <= '0;
      len            <= '0;
      start          <= '0;
      j              <= '0;
      tfi            <= '0;
      input_ready_r  <= 1'b1;
      output_valid_r <= 1'b0;
      output_data_r  <= '0;
      busy_r         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (accept) begin
            if (state == ST_IDLE) begin
              mode_r <= bus.mode;
              busy_r <= 1'b1;
            end
            if (cnt == LAST_IDX) begin
              cnt           <= '0;
              input_ready_r <= 1'b0;
              start         <= '0;
              j             <= '0;
              len           <= (eff_mode == FWD) ? HALF : ONE;
              tfi           <= (eff_mode == FWD) ? ONE : LAST_IDX;
              state         <= ST_CALC;
            end else begin
              cnt   <= cnt + ONE;
              state <= ST_LOAD;
            end
          end
        end
        ST_CALC: begin
          if (blk_end) begin
            tfi <= (mode_r == FWD) ? tfi + ONE : tfi - ONE;
            if (stage_end) begin
              start <= '0;
              j     <= '0;
              len   <= (mode_r == FWD) ? (len >> 1) : (len << 1);
              if (last_stage) begin
                cnt <= '0;
                if (mode_r == FWD) begin
                  output_valid_r <= 1'b1;
                  output_data_r  <= mem[0];
                  state          <= ST_OUTPUT;
                end else begin
                  state <= ST_SCALE;
                end
              end
            end else begin
              start <= next_start[LOGN-1:0];
              j     <= next_start[LOGN-1:0];
            end
          end else begin
            j <= j + ONE;
          end
        end
        ST_SCALE: begin
          if (cnt == LAST_IDX) begin
            cnt            <= '0;
            output_valid_r <= 1'b1;
            output_data_r  <= mem[0];
            state          <= ST_OUTPUT;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        ST_OUTPUT: begin
          if (out_fire) begin
            if (cnt == LAST_IDX) begin
              cnt            <= '0;
              output_valid_r <= 1'b0;
              busy_r         <= 1'b0;
              input_ready_r  <= 1'b1;
              state          <= ST_IDLE;
            end else begin
              cnt           <= cnt + ONE;
              output_data_r <= mem[cnt + ONE];
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_core_param.sv
// Scoreboard bench for ntt_core_param with N=256, Q=8380417. A combinational
// twiddle ROM holds zeta[k] = 1753^brv8(k) mod Q. Stimulus pushes expected
// outputs into a queue; a monitor pops and compares on each output handshake.
module tb_ntt_core_param;
  localparam int          LOGN = 8;
  localparam int          N    = 1 << LOGN;
  localparam int          W    = 23;
  localparam int unsigned Q    = 8380417;
  localparam int unsigned NINV = 8347681;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ntt_core_param_if #(.LOGN(LOGN), .W(W)) bus ();

  ntt_core_param #(.LOGN(LOGN), .W(W), .Q(Q), .NINV(NINV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  logic [W-1:0] zeta_rom [N];
  assign bus.tf_data = zeta_rom[bus.tf_addr];

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] stim [N];
  logic [W-1:0] orig [N];
  logic [W-1:0] cap [N];
  bit           capture_en = 0;
  int           hs_count = 0;
  int           exp_lat = -1;
  int unsigned  last_in_cyc = 0;
  logic         prev_valid = 1'b0;
  bit           held = 0;
  logic [W-1:0] held_data = '0;
  int           stall_at = -1;
  int           stall_len = 0;
  int           stall_left = 0;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: stall stability, first-output latency and scoreboard compare.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
        held       = 0;
      end else begin
        if (held) begin
          checkOutput("stall_valid", 32'(bus.output_valid), 32'd1);
          checkOutput("stall_data", 32'(bus.output_data), 32'(held_data));
        end
        held      = bus.output_valid && !bus.output_ready;
        held_data = bus.output_data;
        if (bus.output_valid && !prev_valid && exp_lat >= 0)
          checkOutput("latency", cyc - last_in_cyc, 32'(exp_lat));
        prev_valid = bus.output_valid;
        if (bus.output_valid && bus.output_ready) begin
          if (capture_en) begin
            if (hs_count < N) cap[hs_count] = bus.output_data;
          end else if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("[TB] FAIL unexpected_output: got %0d at index %0d, expected none",
                     bus.output_data, hs_count);
          end else begin
            checkOutput($sformatf("out[%0d]", hs_count), 32'(bus.output_data),
                        32'(exp_q.pop_front()));
          end
          hs_count++;
        end
      end
    end
  end

  // Sink: ready high except for a planned stall at a given output index.
  initial begin
    bus.output_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        bus.output_ready = 1'b0;
        stall_left--;
      end else if (stall_at >= 0 && hs_count == stall_at && bus.output_valid) begin
        bus.output_ready = 1'b0;
        stall_left = stall_len - 1;
        stall_at = -1;
      end else begin
        bus.output_ready = 1'b1;
      end
    end
  end

  task automatic startRun(input int lat, input bit cap_mode);
    hs_count   = 0;
    exp_lat    = lat;
    capture_en = cap_mode;
    exp_q.delete();
  endtask

  // Streams stim[] in; mode is flipped after the first beat to show it is ignored.
  task automatic applyStimulus(input logic m, input bit gaps);
    int waited;
    bit ok;
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        bus.input_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.input_valid = 1'b1;
      bus.input_data  = stim[i];
      bus.mode        = (i == 0) ? m : ~m;
      waited = 0;
      ok = 0;
      while (!ok && waited < 100) begin
        @(negedge clk);
        if (bus.input_ready) begin
          ok = 1;
          last_in_cyc = cyc;
        end else begin
          waited++;
        end
      end
      if (!ok) begin
        tests++;
        fails++;
        $display("[TB] FAIL input_timeout: beat %0d not accepted, input_ready %0d, expected 1",
                 i, bus.input_ready);
        bus.input_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.input_valid = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int budget;
    budget = 4000;
    while ((hs_count < N || bus.busy) && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    checkOutput({name, "_handshakes"}, 32'(hs_count), 32'(N));
    checkOutput({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    checkOutput({name, "_busy_low"}, 32'(bus.busy), 32'd0);
    checkOutput({name, "_valid_low"}, 32'(bus.output_valid), 32'd0);
    checkOutput({name, "_ready_high"}, 32'(bus.input_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Global bound so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    longint unsigned p;
    int br;
    for (int i = 0; i < N; i++) begin
      br = 0;
      for (int b = 0; b < LOGN; b++) br = br | (((i >> b) & 1) << (LOGN - 1 - b));
      p = 1;
      for (int e = 0; e < br; e++) p = (p * 64'd1753) % 64'(Q);
      zeta_rom[i] = W'(p);
    end
    bus.input_valid = 1'b0;
    bus.input_data  = '0;
    bus.mode        = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_input_ready", 32'(bus.input_ready), 32'd1);
    checkOutput("rst_output_valid", 32'(bus.output_valid), 32'd0);
    checkOutput("rst_output_data", 32'(bus.output_data), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_tf_addr", 32'(bus.tf_addr), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Forward impulse: every evaluation of the constant polynomial 1 is 1.
    for (int i = 0; i < N; i++) stim[i] = (i == 0) ? W'(1) : W'(0);
    startRun(1025, 0);
    for (int i = 0; i < N; i++) exp_q.push_back(W'(1));
    applyStimulus(1'b0, 0);
    waitDone("impulse_fwd");

    // Inverse of all ones is the impulse.
    for (int i = 0; i < N; i++) stim[i] = W'(1);
    startRun(1281, 0);
    for (int i = 0; i < N; i++) exp_q.push_back((i == 0) ? W'(1) : W'(0));
    applyStimulus(1'b1, 0);
    waitDone("impulse_inv");

    // Boundary value Q-1 at x[0]: every output is Q-1.
    for (int i = 0; i < N; i++) stim[i] = (i == 0) ? W'(Q - 1) : W'(0);
    startRun(1025, 0);
    for (int i = 0; i < N; i++) exp_q.push_back(W'(Q - 1));
    applyStimulus(1'b0, 0);
    waitDone("qm1_fwd");

    // Same vector with input gaps and a 5-cycle output stall at index 10.
    startRun(1025, 0);
    for (int i = 0; i < N; i++) exp_q.push_back(W'(Q - 1));
    stall_at  = 10;
    stall_len = 5;
    applyStimulus(1'b0, 1);
    waitDone("qm1_gaps_stall");

    // Round trip: forward a spread vector, feed results back inverse.
    for (int i = 0; i < N; i++) begin
      p = (64'(i) * 64'd62710561 + 64'(i) * 64'(i) * 64'd12345 + 64'd17) % 64'(Q);
      orig[i] = W'(p);
      stim[i] = W'(p);
    end
    startRun(1025, 1);
    applyStimulus(1'b0, 0);
    waitDone("rt_fwd");
    for (int i = 0; i < N; i++) stim[i] = cap[i];
    startRun(1281, 0);
    for (int i = 0; i < N; i++) exp_q.push_back(orig[i]);
    applyStimulus(1'b1, 0);
    waitDone("rt_inv");

    // Reset 300 cycles into CALC, then a fresh impulse transform.
    for (int i = 0; i < N; i++) stim[i] = (i == 0) ? W'(1) : W'(0);
    startRun(-1, 0);
    applyStimulus(1'b0, 0);
    repeat (300) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_input_ready", 32'(bus.input_ready), 32'd1);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_output_valid", 32'(bus.output_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    startRun(1025, 0);
    for (int i = 0; i < N; i++) exp_q.push_back(W'(1));
    applyStimulus(1'b0, 0);
    waitDone("after_rst_fwd");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
